// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, downstream valid/ready handshake and
// the branch redirect coming back from execute.
// master = fetch unit, slave = ROM + execute side.
interface instruction_fetch_unit_if;
   logic [15:0] oIAddress;
   logic [27:0] iInstruction;
   logic        iReady;
   logic        iBranchTaken;
   logic [15:0] iBranchTarget;
   logic [27:0] oInstruction;
   logic [15:0] oPC;
   logic        oValid;

   modport master (
      output oIAddress,
      input  iInstruction,
      input  iReady,
      input  iBranchTaken,
      input  iBranchTarget,
      output oInstruction,
      output oPC,
      output oValid
   );

   modport slave (
      input  oIAddress,
      output iInstruction,
      output iReady,
      output iBranchTaken,
      output iBranchTarget,
      input  oInstruction,
      input  oPC,
      input  oValid
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: addresses the combinational ROM with the PC and
// registers the returned word for downstream, with valid/ready handshake,
// branch redirect and 16-bit PC wrap-around.
// Optional macro FETCH_EARLY_JMP_EN: JMP instructions are resolved in fetch
// and never issued downstream.
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'd0,
   parameter logic [3:0]  JMP_OPCODE = 4'd14
) (
   input logic                      Clock,
   input logic                      Reset,
   instruction_fetch_unit_if.master bus
);

`ifdef FETCH_EARLY_JMP_EN
   localparam logic EARLY_JMP = 1'b1;
`else
   localparam logic EARLY_JMP = 1'b0;
`endif

   typedef enum logic {EMPTY, FULL} state_t;

   state_t      state, state_next;
   logic [15:0] pc, pc_next;
   logic [27:0] instr_q;
   logic [15:0] pc_out_q;
   logic        load;
   logic        is_jmp;
   logic        early_jmp;
   logic        capture;

   assign bus.oIAddress    = pc;
   assign bus.oValid       = (state == FULL);
   assign bus.oInstruction = instr_q;
   assign bus.oPC          = pc_out_q;

   // Next PC / occupancy: branch beats early JMP beats a normal load.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      load       = ((state == EMPTY) || bus.iReady) && !bus.iBranchTaken;
      is_jmp     = (bus.iInstruction[27:24] == JMP_OPCODE);
      early_jmp  = EARLY_JMP && load && is_jmp;
      capture    = load && !early_jmp;
      if (bus.iBranchTaken) begin
         pc_next    = bus.iBranchTarget;
         state_next = EMPTY;
      end else if (early_jmp) begin
         pc_next    = {8'd0, bus.iInstruction[23:16]};
         state_next = EMPTY;
      end else if (load) begin
         pc_next    = pc + 16'd1;
         state_next = FULL;
      end
   end

   // PC and occupancy registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pc    <= RESET_PC;
         state <= EMPTY;
      end else begin
         pc    <= pc_next;
         state <= state_next;
      end
   end

   // Output instruction/PC latch; holds its stale contents across flushes.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         instr_q  <= 28'd0;
         pc_out_q <= 16'd0;
      end else if (capture) begin
         instr_q  <= bus.iInstruction;
         pc_out_q <= pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: fill, stall, branch flush,
// PC wrap, async reset mid-stall and JMP handling (both macro builds).
module tb_instruction_fetch_unit;

   localparam logic [3:0] JMP_OP = 4'd14;

   logic Clock;
   logic Reset;
   logic jmp_rom;
   int   vec_cnt;
   int   err_cnt;

   instruction_fetch_unit_if bus();

   instruction_fetch_unit #(
      .RESET_PC  (16'd0),
      .JMP_OPCODE(JMP_OP)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ROM word = {4'h2, 8'hA5, address}; optionally a JMP to 1 at address 5.
   function automatic logic [27:0] rom_word(input logic [15:0] a);
      return {4'h2, 8'hA5, a};
   endfunction

   assign bus.iInstruction = (jmp_rom && bus.oIAddress == 16'd5) ?
                             {JMP_OP, 8'd1, 16'd0} : rom_word(bus.oIAddress);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [15:0] opc,
                             input logic [15:0] addr);
      check({tag, ".valid"}, 32'(bus.oValid), 32'(v));
      check({tag, ".opc"},   32'(bus.oPC), 32'(opc));
      check({tag, ".addr"},  32'(bus.oIAddress), 32'(addr));
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      Reset = 1'b1;
      jmp_rom = 1'b0;
      bus.iReady = 1'b0;
      bus.iBranchTaken = 1'b0;
      bus.iBranchTarget = 16'd0;
      step();
      step();
      // Reset state
      expect_out("rst", 1'b0, 16'd0, 16'd0);
      check("rst.instr", 32'(bus.oInstruction), 32'd0);

      Reset = 1'b0;
      bus.iReady = 1'b1;
      check("rel.addr", 32'(bus.oIAddress), 32'd0);
      step();
      expect_out("f0", 1'b1, 16'd0, 16'd1);
      check("f0.instr", 32'(bus.oInstruction), 32'h2A50000);
      step();
      expect_out("f1", 1'b1, 16'd1, 16'd2);
      step();
      expect_out("f2", 1'b1, 16'd2, 16'd3);

      // Stall three cycles
      bus.iReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("stall", 1'b1, 16'd2, 16'd3);
         check("stall.instr", 32'(bus.oInstruction), 32'h2A50002);
      end
      bus.iReady = 1'b1;
      step();
      expect_out("unstall", 1'b1, 16'd3, 16'd4);
      step();
      step();
      expect_out("pre_br", 1'b1, 16'd5, 16'd6);

      // Branch with iReady=1 and oValid=1: branch wins, one bubble
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'h0040;
      step();
      expect_out("br", 1'b0, 16'd5, 16'h0040);
      bus.iBranchTaken = 1'b0;
      step();
      expect_out("br_tgt", 1'b1, 16'h0040, 16'h0041);
      check("br_tgt.instr", 32'(bus.oInstruction), 32'h2A50040);

      // Wrap-around
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'hFFFF;
      step();
      expect_out("wrap_br", 1'b0, 16'h0040, 16'hFFFF);
      bus.iBranchTaken = 1'b0;
      step();
      expect_out("wrap0", 1'b1, 16'hFFFF, 16'h0000);
      step();
      expect_out("wrap1", 1'b1, 16'h0000, 16'h0001);

      // Branch during a stall (iReady=0) still redirects
      bus.iReady = 1'b0;
      bus.iBranchTaken = 1'b1;
      bus.iBranchTarget = 16'd7;
      step();
      expect_out("br_stall", 1'b0, 16'h0000, 16'd7);
      bus.iBranchTaken = 1'b0;
      step();
      expect_out("ld7", 1'b1, 16'd7, 16'd8);
      step();
      expect_out("hold7", 1'b1, 16'd7, 16'd8);

      // Asynchronous reset mid-stall, observed before the next edge
      #3;
      Reset = 1'b1;
      #1;
      expect_out("arst", 1'b0, 16'd0, 16'd0);
      check("arst.instr", 32'(bus.oInstruction), 32'd0);

      // JMP at address 5
      step();
      Reset = 1'b0;
      jmp_rom = 1'b1;
      bus.iReady = 1'b1;
      for (int i = 0; i < 5; i++) step();
      expect_out("j4", 1'b1, 16'd4, 16'd5);
      step();
`ifdef FETCH_EARLY_JMP_EN
      expect_out("j_bub", 1'b0, 16'd4, 16'd1);
      check("j_bub.instr", 32'(bus.oInstruction), 32'h2A50004);
      step();
      expect_out("j_t1", 1'b1, 16'd1, 16'd2);
      step();
      expect_out("j_t2", 1'b1, 16'd2, 16'd3);
`else
      expect_out("j5", 1'b1, 16'd5, 16'd6);
      check("j5.instr", 32'(bus.oInstruction), 32'hE010000);
      step();
      expect_out("j6", 1'b1, 16'd6, 16'd7);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage between the program counter and the execute/decode stage of the Experimento-2 processor.
- Drives the address into the combinational instruction ROM and latches the returned 28-bit instruction into a registered output.
- Hands that instruction downstream with a valid/ready handshake.
- Handles stalls, branch redirects from execute, and PC wrap-around.

Parameters:
- RESET_PC, 16'd0, PC value loaded on reset.
- JMP_OPCODE, 4'd?, opcode value of `JMP`, compared against instruction bits [27:24]. Set from the project definitions include at instantiation.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- oIAddress  output  16  ROM address. Combinational copy of the internal PC register.
- iInstruction  input  28  ROM data. Combinational response to oIAddress in the same cycle.
- iReady  input  1  downstream can accept oInstruction this cycle.
- iBranchTaken  input  1  execute stage redirects fetch this cycle.
- iBranchTarget  input  16  redirect address, sampled when iBranchTaken=1.
- oInstruction  output  28  registered instruction for downstream.
- oPC  output  16  address the current oInstruction was fetched from.
- oValid  output  1  oInstruction/oPC hold a live instruction.

Behaviour:
- Reset (async, Reset=1): PC=RESET_PC, oInstruction=28'd0, oPC=16'd0, oValid=0. Takes effect immediately, mid-stall or mid-branch included. First fetch is on the first rising edge after Reset falls.
- Load condition: load = (!oValid || iReady) && !iBranchTaken.
- On a clock edge with load=1:
  - oInstruction <= iInstruction
  - oPC <= PC
  - oValid <= 1
  - PC <= PC+1
- Stall (oValid=1, iReady=0, iBranchTaken=0): PC, oInstruction, oPC and oValid all hold. oIAddress stays constant.
- Branch (iBranchTaken=1): highest priority regardless of iReady or oValid.
  - PC <= iBranchTarget
  - oValid <= 0 (the in-flight instruction is flushed)
  - oInstruction/oPC hold their stale values.
  - Next cycle fetches from the target.
- Latency:
  - Instruction at address A appears on oInstruction one clock after PC=A, given no stall.
  - After a branch, the target instruction is valid 2 clocks after the iBranchTaken edge: one flush bubble.
- Throughput: 1 instruction/clock while iReady=1.
- PC arithmetic: 16-bit unsigned, wraps 16'hFFFF -> 16'h0000 with no flag.
- Handshake: a transfer occurs on an edge where oValid=1 and iReady=1. Downstream must not assume oInstruction is stable while oValid=0.
- Simultaneous iBranchTaken=1 and iReady=1 with oValid=1: the held instruction counts as consumed. Branch wins, and the next oValid is 0.
- No internal FSM beyond the PC/valid registers. States are EMPTY (oValid=0) and FULL (oValid=1):
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on branch.
  - FULL -> FULL on transfer or stall.

Optional Feature:
- Macro: FETCH_EARLY_JMP_EN.
- Defined:
  - On a load where iInstruction[27:24]==JMP_OPCODE, the JMP is consumed in fetch.
  - PC <= {8'd0, iInstruction[23:16]}, oValid <= 0, no PC+1.
  - Net cost is one bubble. Downstream never sees JMP.
  - iBranchTaken still has priority over this redirect.
- Undefined: JMP is loaded and issued like any other instruction. Execute resolves it via iBranchTaken.

Test Plan:
- Reset, release, iReady=1, ROM returns addr-tagged words -> oIAddress 0,1,2,3 on successive cycles; oPC 0,1,2 with oValid=1 from the 1st edge after release.
- Hold iReady=0 for 3 cycles while oValid=1, oPC=2 -> oPC=2, oInstruction and oIAddress=3 frozen; release -> oPC=3 next edge.
- iBranchTaken=1, iBranchTarget=16'h0040 while oPC=5 -> next edge oValid=0, oIAddress=0x40; following edge oPC=0x40, oValid=1.
- Force PC to 16'hFFFF via branch, iReady=1 -> oPC=0xFFFF then 0x0000, with no glitch on oValid.
- Assert Reset asynchronously mid-stall (oValid=1, oPC=7) -> oValid=0, oIAddress=0 before the next clock edge.
- FETCH_EARLY_JMP_EN defined, ROM word at addr 5 = {JMP_OPCODE, 8'd1, 16'd0} -> oPC sequence ...4, bubble, 1, 2; oInstruction never shows the JMP. Undefined -> JMP is issued with oPC=5.
